// File: rtl/johnson_counter_gen_pkg.sv
// Shared Johnson-ring helpers: legal code per phase index and phase-index width.
// Latency: n/a (pure functions, used at elaboration and in combinational decode).
// Backpressure: n/a.
//
// Contents:
//   MAXW          widest ring the helpers can describe
//   johnson_code  phase index k -> legal ring code for a ring of the given width
//   phase_w       number of bits needed to index the 2*width phases
package johnson_pkg;

    localparam int MAXW = 32;

    // Legal ring code for phase k.
    // The first half of the sequence fills with ones from the LSB up:
    //   k <= width : (1 << k) - 1
    // The second half drains those ones from the LSB up:
    //   k >  width : ones << (k - width), masked to width bits
    // The arithmetic is done at 64 bits so that width == 32 does not overflow the shift.
    function automatic logic [MAXW-1:0] johnson_code(input int k, input int width);
        logic [63:0] ones;
        logic [63:0] c;
        ones = (64'd1 << width) - 64'd1;
        if (k <= width) begin
            c = (64'd1 << k) - 64'd1;
        end else begin
            c = (ones << (k - width)) & ones;
        end
        return 32'(c);
    endfunction

    // Width of a phase index for a ring of the given width (2*width phases).
    function automatic int phase_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/johnson_counter_gen_if.sv
// Control and status bundle for the Johnson counter: step/load controls in, ring state and decodes out.
// Latency: n/a (wiring only).
// Backpressure: none; the counter accepts a control word every cycle.
//
// Signals:
//   en, dir            step enable and direction (0 = forward, 1 = reverse)
//   load, load_phase   synchronous phase load; load wins over en
//   q                  registered ring state
//   phase              phase index decoded from q (0 when q is illegal)
//   phase_onehot       bit[phase] set; all-zero when q is illegal
//   wrap               one-cycle pulse when a step crosses the last/first phase boundary
//   illegal            q is not one of the legal ring codes
interface johnson_counter_gen_if #(
    parameter int WIDTH = 4
);

    localparam int PW  = johnson_pkg::phase_w(WIDTH);
    localparam int NPH = 2 * WIDTH;

    logic             en;
    logic             dir;
    logic             load;
    logic [PW-1:0]    load_phase;
    logic [WIDTH-1:0] q;
    logic [PW-1:0]    phase;
    logic [NPH-1:0]   phase_onehot;
    logic             wrap;
    logic             illegal;

    // master drives the controls and observes the counter
    modport master (
        output en, dir, load, load_phase,
        input  q, phase, phase_onehot, wrap, illegal
    );

    // slave is the counter itself
    modport slave (
        input  en, dir, load, load_phase,
        output q, phase, phase_onehot, wrap, illegal
    );

endinterface

// File: rtl/johnson_counter_gen_decode.sv
// Ring-code decoder: maps a Johnson ring state to phase index, one-hot phase and illegal flag.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   q             ring state to decode
//   phase         index of the matching legal code, 0 if none matches
//   phase_onehot  bit k set when q equals the code for phase k
//   illegal       no legal code matches q
module johnson_decode
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int PW    = phase_w(WIDTH),
    localparam int NPH   = 2 * WIDTH
) (
    input  logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic [NPH-1:0]   phase_onehot,
    output logic             illegal
);

    // The legal codes are all distinct, so at most one bit of phase_onehot can be set
    // and the index loop never has two writers for phase.
    always_comb begin
        phase        = '0;
        phase_onehot = '0;
        for (int k = 0; k < NPH; k++) begin
            if (q == WIDTH'(johnson_code(k, WIDTH))) begin
                phase_onehot[k] = 1'b1;
                phase           = PW'(k);
            end
        end
    end

    assign illegal = ~|phase_onehot;

endmodule

// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson (twisted-ring) counter with bidirectional step, phase load, wrap pulse and illegal-state recovery.
// Latency: q/phase/phase_onehot/wrap update one cycle after en/load are sampled; decodes are combinational off q.
// Backpressure: none; a step or load is taken on every edge it is requested.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (q = 0, wrap = 0)
//   bus   johnson_counter_gen_if.slave: en/dir/load/load_phase in; q/phase/phase_onehot/wrap/illegal out
//
// Parameters:
//   WIDTH         ring width in flops (>= 2); sequence length 2*WIDTH
//   SELF_CORRECT  1: an illegal ring code is forced to phase 0 on the next edge; 0: only flagged
module johnson_counter_gen
    import johnson_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter bit SELF_CORRECT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    johnson_counter_gen_if.slave  bus
);

    localparam int PW  = phase_w(WIDTH);
    localparam int NPH = 2 * WIDTH;

    // Code of the last phase; a forward step from here (or a reverse step into here) wraps.
    localparam logic [WIDTH-1:0] LAST_CODE = WIDTH'(johnson_code(NPH - 1, WIDTH));

    logic [WIDTH-1:0] ring_q;
    logic [WIDTH-1:0] ring_d;
    logic [WIDTH-1:0] ring_fwd;
    logic [WIDTH-1:0] ring_rev;
    logic [WIDTH-1:0] load_code;
    logic [PW-1:0]    lp_clamped;
    logic             wrap_q;
    logic             wrap_d;
    logic             illegal;

    // Ring steps. The twist (inverted feedback) is what makes the sequence 2*WIDTH long.
    assign ring_fwd = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
    assign ring_rev = {~ring_q[0], ring_q[WIDTH-1:1]};

    // Out-of-range load targets saturate at the last phase. The compare is done at 32 bits
    // because NPH can equal 2**PW, which would alias to zero at PW bits.
    always_comb begin
        lp_clamped = bus.load_phase;
        if (32'(bus.load_phase) >= NPH) begin
            lp_clamped = PW'(NPH - 1);
        end
    end

    assign load_code = WIDTH'(johnson_code(int'(lp_clamped), WIDTH));

    // Next-state mux: load > illegal correction > step > hold. Reset is applied in the register.
    // wrap is only raised by a real step across the boundary; loads and corrections never pulse it.
    // An illegal code can never equal 0 or LAST_CODE, so stepping an uncorrected illegal ring
    // cannot fake a wrap.
    always_comb begin
        ring_d = ring_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            ring_d = load_code;
        end else if (illegal && SELF_CORRECT) begin
            ring_d = '0;
        end else if (bus.en) begin
            if (bus.dir) begin
                ring_d = ring_rev;
                wrap_d = (ring_q == '0);
            end else begin
                ring_d = ring_fwd;
                wrap_d = (ring_q == LAST_CODE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            ring_q <= ring_d;
            wrap_q <= wrap_d;
        end
    end

    johnson_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .q            (ring_q),
        .phase        (bus.phase),
        .phase_onehot (bus.phase_onehot),
        .illegal      (illegal)
    );

    assign bus.q       = ring_q;
    assign bus.wrap    = wrap_q;
    assign bus.illegal = illegal;

endmodule

// File: tb/tb_johnson_counter_gen.sv
// Bench for johnson_counter_gen: three instances (W4 self-correcting, W4 flag-only, W5 self-correcting)
// stepped in lockstep; expected state is pushed per edge and popped after the edge.
module tb_johnson_counter_gen;
    import johnson_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    johnson_counter_gen_if #(.WIDTH(4)) bus_a ();
    johnson_counter_gen_if #(.WIDTH(4)) bus_b ();
    johnson_counter_gen_if #(.WIDTH(5)) bus_c ();

    johnson_counter_gen #(.WIDTH(4), .SELF_CORRECT(1'b1)) u_sc (.clk(clk), .rst(rst), .bus(bus_a));
    johnson_counter_gen #(.WIDTH(4), .SELF_CORRECT(1'b0)) u_nc (.clk(clk), .rst(rst), .bus(bus_b));
    johnson_counter_gen #(.WIDTH(5), .SELF_CORRECT(1'b1)) u_w5 (.clk(clk), .rst(rst), .bus(bus_c));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int          wid [3] = '{4, 4, 5};
    bit          scf [3] = '{1'b1, 1'b0, 1'b1};
    logic        en_v  [3];
    logic        dir_v [3];
    logic        ld_v  [3];
    int          lp_v  [3];
    logic [31:0] m_q   [3];

    logic [3:0] t1_q [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                             4'b1100, 4'b1000, 4'b0000, 4'b0001};
    int         t1_p [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    logic [3:0] t2_q [3] = '{4'b1000, 4'b1100, 4'b1110};
    int         wraps;

    typedef struct {
        int          id;
        logic [31:0] q;
        logic [31:0] phase;
        logic [31:0] oh;
        logic        wrap;
        logic        ill;
        string       tag;
    } exp_t;

    exp_t sb [$];

    // Phase index of a legal code, -1 for an illegal one.
    function automatic int phase_of(input logic [31:0] q, input int w);
        int p;
        p = -1;
        for (int k = 0; k < 2 * w; k++) begin
            if (q == johnson_code(k, w)) p = k;
        end
        return p;
    endfunction

    // Reference: {wrap, q} after one edge. Legal rings move by phase arithmetic;
    // only an uncorrected illegal ring is shifted bit by bit.
    function automatic logic [32:0] model_next(input logic [31:0] q, input int w, input bit sc,
                                               input logic r, input logic en, input logic dir,
                                               input logic ld, input int lp);
        int          n;
        int          p;
        int          np;
        logic [31:0] mask;
        logic [31:0] nq;
        n    = 2 * w;
        p    = phase_of(q, w);
        mask = (32'd1 << w) - 32'd1;
        if (r) return 33'd0;
        if (ld) return {1'b0, johnson_code((lp >= n) ? n - 1 : lp, w)};
        if (p < 0 && sc) return 33'd0;
        if (!en) return {1'b0, q};
        if (p >= 0) begin
            np = dir ? (p + n - 1) % n : (p + 1) % n;
            return {(dir ? (p == 0) : (p == n - 1)), johnson_code(np, w)};
        end
        if (dir) nq = (q >> 1) | ({31'd0, ~q[0]} << (w - 1));
        else     nq = ((q << 1) | {31'd0, ~q[w-1]}) & mask;
        return {1'b0, nq};
    endfunction

    task automatic set(input int i, input logic en, input logic dir, input logic ld, input int lp);
        en_v[i]  = en;
        dir_v[i] = dir;
        ld_v[i]  = ld;
        lp_v[i]  = lp;
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) set(i, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Drive the current control words, queue expectations, take one edge, check all queued entries.
    task automatic tick(input string tag);
        logic [32:0] nx;
        exp_t        e;
        int          p;
        logic [31:0] oq, oph, ooh;
        logic        ow, oi;
        bus_a.en = en_v[0]; bus_a.dir = dir_v[0]; bus_a.load = ld_v[0]; bus_a.load_phase = 3'(lp_v[0]);
        bus_b.en = en_v[1]; bus_b.dir = dir_v[1]; bus_b.load = ld_v[1]; bus_b.load_phase = 3'(lp_v[1]);
        bus_c.en = en_v[2]; bus_c.dir = dir_v[2]; bus_c.load = ld_v[2]; bus_c.load_phase = 4'(lp_v[2]);
        for (int i = 0; i < 3; i++) begin
            nx     = model_next(m_q[i], wid[i], scf[i], rst, en_v[i], dir_v[i], ld_v[i], lp_v[i]);
            m_q[i] = nx[31:0];
            p      = phase_of(m_q[i], wid[i]);
            e.id    = i;
            e.q     = m_q[i];
            e.phase = (p < 0) ? 32'd0 : 32'(p);
            e.oh    = (p < 0) ? 32'd0 : (32'd1 << p);
            e.wrap  = nx[32];
            e.ill   = (p < 0);
            e.tag   = tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.id)
                0:       begin oq = 32'(bus_a.q); oph = 32'(bus_a.phase); ooh = 32'(bus_a.phase_onehot);
                               ow = bus_a.wrap; oi = bus_a.illegal; end
                1:       begin oq = 32'(bus_b.q); oph = 32'(bus_b.phase); ooh = 32'(bus_b.phase_onehot);
                               ow = bus_b.wrap; oi = bus_b.illegal; end
                default: begin oq = 32'(bus_c.q); oph = 32'(bus_c.phase); ooh = 32'(bus_c.phase_onehot);
                               ow = bus_c.wrap; oi = bus_c.illegal; end
            endcase
            chk($sformatf("%s_q%0d", e.tag, e.id), oq, e.q);
            chk($sformatf("%s_phase%0d", e.tag, e.id), oph, e.phase);
            chk($sformatf("%s_onehot%0d", e.tag, e.id), ooh, e.oh);
            chk($sformatf("%s_wrap%0d", e.tag, e.id), 32'(ow), 32'(e.wrap));
            chk($sformatf("%s_illegal%0d", e.tag, e.id), 32'(oi), 32'(e.ill));
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m_q[i] = 32'd0;
        rst = 1'b1;
        idle();
        @(negedge clk);

        // Reset state
        tick("rst");
        tick("rst");
        chk("rst_q", 32'(bus_a.q), 32'd0);
        chk("rst_phase", 32'(bus_a.phase), 32'd0);
        chk("rst_onehot", 32'(bus_a.phase_onehot), 32'd1);
        chk("rst_wrap", 32'(bus_a.wrap), 32'd0);
        chk("rst_illegal", 32'(bus_a.illegal), 32'd0);
        rst = 1'b0;

        // Forward sequence through the wrap
        for (int j = 0; j < 9; j++) begin
            set(0, 1'b1, 1'b0, 1'b0, 0);
            set(1, 1'b1, 1'b0, 1'b0, 0);
            tick("t1");
            chk("t1_lit_q", 32'(bus_a.q), 32'(t1_q[j]));
            chk("t1_lit_phase", 32'(bus_a.phase), 32'(t1_p[j]));
            chk("t1_lit_wrap", 32'(bus_a.wrap), (j == 7) ? 32'd1 : 32'd0);
        end

        // Reverse from reset, then hold
        rst = 1'b1; idle(); tick("t2_rst"); rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            set(0, 1'b1, 1'b1, 1'b0, 0);
            tick("t2");
            chk("t2_lit_q", 32'(bus_a.q), 32'(t2_q[j]));
            chk("t2_lit_wrap", 32'(bus_a.wrap), (j == 0) ? 32'd1 : 32'd0);
        end
        idle();
        tick("t2_hold");
        tick("t2_hold");
        chk("t2_hold_q", 32'(bus_a.q), 32'b1110);
        chk("t2_hold_wrap", 32'(bus_a.wrap), 32'd0);

        // Load beats en; out-of-range target clamps on the 5-bit ring
        set(0, 1'b1, 1'b0, 1'b1, 5);
        set(2, 1'b1, 1'b0, 1'b1, 12);
        tick("t3");
        chk("t3_load_q", 32'(bus_a.q), 32'b1110);
        chk("t3_load_onehot", 32'(bus_a.phase_onehot), 32'b0010_0000);
        chk("t3_clamp_q", 32'(bus_c.q), 32'b10000);
        chk("t3_clamp_phase", 32'(bus_c.phase), 32'd9);
        idle();
        set(0, 1'b0, 1'b0, 1'b1, 7);
        tick("t3b");
        chk("t3_load7_q", 32'(bus_a.q), 32'b1000);

        // Reset overrides load and en mid-sequence
        rst = 1'b1; idle(); tick("t5_rst"); rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            set(0, 1'b1, 1'b0, 1'b0, 0);
            tick("t5_pre");
        end
        chk("t5_pre_q", 32'(bus_a.q), 32'b0111);
        rst = 1'b1;
        set(0, 1'b1, 1'b0, 1'b1, 5);
        tick("t5");
        chk("t5_rst_q", 32'(bus_a.q), 32'd0);
        chk("t5_rst_wrap", 32'(bus_a.wrap), 32'd0);
        rst = 1'b0;
        idle();

        // Illegal code: corrected on one instance, only flagged on the other
        force u_sc.ring_q = 4'b0101;
        force u_nc.ring_q = 4'b0101;
        #1;
        release u_sc.ring_q;
        release u_nc.ring_q;
        #1;
        chk("t4_sc_illegal", 32'(bus_a.illegal), 32'd1);
        chk("t4_sc_phase", 32'(bus_a.phase), 32'd0);
        chk("t4_sc_onehot", 32'(bus_a.phase_onehot), 32'd0);
        chk("t4_nc_illegal", 32'(bus_b.illegal), 32'd1);
        m_q[0] = 32'b0101;
        m_q[1] = 32'b0101;
        set(0, 1'b1, 1'b1, 1'b0, 0);
        set(1, 1'b1, 1'b0, 1'b0, 0);
        tick("t4");
        chk("t4_sc_fix_q", 32'(bus_a.q), 32'd0);
        chk("t4_sc_fix_wrap", 32'(bus_a.wrap), 32'd0);
        chk("t4_nc_q", 32'(bus_b.q), 32'b1011);
        chk("t4_nc_still_illegal", 32'(bus_b.illegal), 32'd1);
        set(1, 1'b1, 1'b1, 1'b0, 0);
        tick("t4_nc_rev");
        set(1, 1'b1, 1'b0, 1'b1, 3);
        tick("t4_nc_load");
        chk("t4_nc_load_q", 32'(bus_b.q), 32'b0111);
        chk("t4_nc_load_illegal", 32'(bus_b.illegal), 32'd0);

        // 5-bit ring: a full forward lap gives exactly one wrap
        rst = 1'b1; idle(); tick("t6_rst"); rst = 1'b0;
        wraps = 0;
        for (int j = 0; j < 10; j++) begin
            set(2, 1'b1, 1'b0, 1'b0, 0);
            tick("t6");
            wraps += int'(bus_c.wrap);
        end
        chk("t6_end_q", 32'(bus_c.q), 32'd0);
        chk("t6_wraps", 32'(wraps), 32'd1);

        // Random controls against the reference
        for (int j = 0; j < 400; j++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 3; i++) begin
                set(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, (i == 2) ? 15 : 7)));
            end
            tick("rnd");
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
